// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, ASCII constants and bit-timing helper for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - single-byte 8N1 serializer with valid/ready handshake
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] data,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  uart_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      tx      <= tx_n;
    end
  end

  // STOP lasts one bit-time minus a cycle: the IDLE cycle that follows is the
  // final stop-bit cycle, so a waiting byte can start with no gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = tx;
    case (state)
      IDLE: begin
        if (valid) begin
          state_n = START;
          cnt_n   = '0;
          sh_n    = data;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (cnt == BIT_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = shreg >> 1;
            tx_n  = shreg[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == STOP_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

endmodule

// File: rtl/uart_buffer_tx.sv
// rtl/uart_buffer_tx.sv - snapshots the character buffer and streams it out as 8N1 frames
module uart_buffer_tx
  import uart_pkg::*;
#(
  parameter int NUM_CHARS   = 60,
  parameter int CHAR_WIDTH  = 8,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int APPEND_CRLF = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHARS*CHAR_WIDTH-1:0]   characters,
  input  logic                              start,
  output logic                              uart_tx,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_CHARS+2)-1:0]    char_idx
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW    = $clog2(NUM_CHARS + 2);
  localparam int TOTAL = NUM_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

  logic [NUM_CHARS*CHAR_WIDTH-1:0] snap;
  logic [IW-1:0] next_idx;
  logic [7:0]    next_char;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          last_char;

  assign next_idx  = char_idx + 1'b1;
  assign last_char = (char_idx == LAST_IDX);

  always_comb begin
    next_char = ASCII_LF;
    if (next_idx == IW'(NUM_CHARS)) next_char = ASCII_CR;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (next_idx == IW'(i)) next_char = snap[i*CHAR_WIDTH +: 8];
    end
  end

  // The first byte comes straight off the bus so its start bit follows the
  // request by one cycle; the snapshot serves every later byte.
  assign byte_valid = busy ? (byte_ready && !last_char) : start;
  assign byte_data  = busy ? next_char : characters[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      char_idx <= '0;
    end else if (!busy) begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        snap     <= characters;
        char_idx <= '0;
      end
    end else if (byte_ready) begin
      if (last_char) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        char_idx <= next_idx;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_tx_byte (
    .clk   (clk),
    .reset (reset),
    .valid (byte_valid),
    .ready (byte_ready),
    .data  (byte_data),
    .tx    (uart_tx)
  );

endmodule
